// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store sequencer between load buffer, ROB store queue, dcache and CDB
module mem_access_ctrl #(
    parameter int data_width     = 16,
    parameter int rob_addr_width = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      ld_valid,
    input  logic [data_width-1:0]     ld_addr,
    input  logic [rob_addr_width-1:0] ld_dest,
    output logic                      ld_RE,
    input  logic                      st_valid,
    input  logic [data_width-1:0]     st_addr,
    input  logic [data_width-1:0]     st_data,
    output logic                      st_ack,
    output logic                      dmem_read,
    output logic                      dmem_write,
    output logic [data_width-1:0]     dmem_address,
    output logic [data_width-1:0]     dmem_wdata,
    input  logic [data_width-1:0]     dmem_rdata,
    input  logic                      dmem_resp,
    output logic                      cdb_req,
    output logic [rob_addr_width-1:0] cdb_tag,
    output logic [data_width-1:0]     cdb_data,
    input  logic                      cdb_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        BCAST = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [data_width-1:0]     addr_q;
    logic [data_width-1:0]     wdata_q;
    logic [data_width-1:0]     rdata_q;
    logic [rob_addr_width-1:0] tag_q;
    logic                      last_served_st;
    logic                      flush_seen;
    logic                      accept_ld;
    logic                      accept_st;
    logic                      ld_ok;
    logic                      load_killed;

    // Loads are speculative and may not start while a flush is in progress.
    assign ld_ok       = ld_valid && !flush;
    assign load_killed = flush || flush_seen;

    always_comb begin
        state_nxt    = state;
        accept_ld    = 1'b0;
        accept_st    = 1'b0;
        ld_RE        = 1'b0;
        st_ack       = 1'b0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = '0;
        dmem_wdata   = '0;
        cdb_req      = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
        case (state)
            IDLE: begin
                if (st_valid && ld_ok) begin
                    accept_ld = last_served_st;
                    accept_st = !last_served_st;
                end else begin
                    accept_st = st_valid;
                    accept_ld = ld_ok;
                end
                if (accept_st) state_nxt = STORE;
                if (accept_ld) state_nxt = LOAD;
                // The pop is combinational, so keep it quiet while reset holds the FSM.
                ld_RE = accept_ld && !reset;
            end
            LOAD: begin
                dmem_read    = 1'b1;
                dmem_address = addr_q;
                if (dmem_resp) state_nxt = load_killed ? IDLE : BCAST;
            end
            STORE: begin
                dmem_write   = 1'b1;
                dmem_address = addr_q;
                dmem_wdata   = wdata_q;
                if (dmem_resp) begin
                    st_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BCAST: begin
                cdb_req  = 1'b1;
                cdb_tag  = tag_q;
                cdb_data = rdata_q;
                if (cdb_grant || flush) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            tag_q          <= '0;
            last_served_st <= 1'b0;
            flush_seen     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_ld) begin
                addr_q         <= ld_addr;
                tag_q          <= ld_dest;
                last_served_st <= 1'b0;
                flush_seen     <= 1'b0;
            end
            if (accept_st) begin
                addr_q         <= st_addr;
                wdata_q        <= st_data;
                last_served_st <= 1'b1;
            end
            // A flushed load still completes its cache access; only the result is dropped.
            if (state == LOAD) begin
                if (flush) flush_seen <= 1'b1;
                if (dmem_resp && !load_killed) rdata_q <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - vector table plus directed sequences for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_addr = '0;
    logic [RW-1:0] ld_dest = '0;
    logic          ld_RE;
    logic          st_valid = 1'b0;
    logic [DW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_ack;
    logic          dmem_read;
    logic          dmem_write;
    logic [DW-1:0] dmem_address;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;
    logic          dmem_resp = 1'b0;
    logic          cdb_req;
    logic [RW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          cdb_grant = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.data_width(DW), .rob_addr_width(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_dest(ld_dest), .ld_RE(ld_RE),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ack(st_ack),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_grant(cdb_grant)
    );

    typedef struct {
        string         name;
        logic          rst, fl, ldv;
        logic [DW-1:0] lda;
        logic [RW-1:0] ldd;
        logic          stv;
        logic [DW-1:0] sta, std, rd;
        logic          resp, gnt;
        logic          e_ldre, e_stack, e_rd, e_wr;
        logic [DW-1:0] e_addr, e_wdata;
        logic          e_req;
        logic [RW-1:0] e_tag;
        logic [DW-1:0] e_cdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input string name, input logic rst, input logic fl, input logic ldv,
                              input logic [DW-1:0] lda, input logic [RW-1:0] ldd, input logic stv,
                              input logic [DW-1:0] sta, input logic [DW-1:0] std, input logic [DW-1:0] rd,
                              input logic resp, input logic gnt, input logic e_ldre, input logic e_stack,
                              input logic e_rd, input logic e_wr, input logic [DW-1:0] e_addr,
                              input logic [DW-1:0] e_wdata, input logic e_req, input logic [RW-1:0] e_tag,
                              input logic [DW-1:0] e_cdata);
        vec_t t;
        t = '{name, rst, fl, ldv, lda, ldd, stv, sta, std, rd, resp, gnt,
              e_ldre, e_stack, e_rd, e_wr, e_addr, e_wdata, e_req, e_tag, e_cdata};
        vecs.push_back(t);
    endfunction

    task automatic chk(input string tag, input string sig, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", tag, sig, act, req_v, $time);
        end
    endtask

    task automatic chk_row(input vec_t r);
        chk(r.name, "ld_RE", ld_RE, r.e_ldre);
        chk(r.name, "st_ack", st_ack, r.e_stack);
        chk(r.name, "dmem_read", dmem_read, r.e_rd);
        chk(r.name, "dmem_write", dmem_write, r.e_wr);
        chk(r.name, "dmem_address", dmem_address, r.e_addr);
        chk(r.name, "dmem_wdata", dmem_wdata, r.e_wdata);
        chk(r.name, "cdb_req", cdb_req, r.e_req);
        chk(r.name, "cdb_tag", cdb_tag, r.e_tag);
        chk(r.name, "cdb_data", cdb_data, r.e_cdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int    ev_n;
        int    ldre_cnt;
        int    stack_cnt;
        string ev;
        string ev_req;

        //  name          rst fl ldv lda      ldd stv sta      std      rdata    rsp gnt | ldre ack rd wr addr     wdata    req tag cdata
        v("reset",        1, 0, 1, 'h1234, 5, 1, 'h00A0, 'h5A5A, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("ld_accept",    0, 0, 1, 'h1234, 5, 0, 'h0000, 'h0000, 'h0000, 0, 0,   1, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("ld_wait1",     0, 0, 0, 'hFFFF, 7, 0, 'h0000, 'h0000, 'hDEAD, 0, 0,   0, 0, 1, 0, 'h1234, 'h0000, 0, 0, 'h0000);
        v("ld_wait2",     0, 0, 0, 'hFFFF, 7, 0, 'h0000, 'h0000, 'hDEAD, 0, 0,   0, 0, 1, 0, 'h1234, 'h0000, 0, 0, 'h0000);
        v("ld_resp",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'hBEEF, 1, 0,   0, 0, 1, 0, 'h1234, 'h0000, 0, 0, 'h0000);
        v("ld_bcast",     0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 1,   0, 0, 0, 0, 'h0000, 'h0000, 1, 5, 'hBEEF);
        v("ld_idle",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("st_accept",    0, 0, 0, 'h0000, 0, 1, 'h00A0, 'h5A5A, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("st_wait",      0, 0, 0, 'h0000, 0, 0, 'hFFFF, 'hFFFF, 'h0000, 0, 0,   0, 0, 0, 1, 'h00A0, 'h5A5A, 0, 0, 'h0000);
        v("st_resp",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 1, 0,   0, 1, 0, 1, 'h00A0, 'h5A5A, 0, 0, 'h0000);
        v("st_idle",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("fl_noacc",     0, 1, 1, 'h0042, 3, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("fl_idle",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("fl_ld_acc",    0, 0, 1, 'h0042, 3, 0, 'h0000, 'h0000, 'h0000, 0, 0,   1, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("fl_ld_flush",  0, 1, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 1, 0, 'h0042, 'h0000, 0, 0, 'h0000);
        v("fl_ld_wait",   0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 1, 0, 'h0042, 'h0000, 0, 0, 'h0000);
        v("fl_ld_resp",   0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h1111, 1, 1,   0, 0, 1, 0, 'h0042, 'h0000, 0, 0, 'h0000);
        v("fl_ld_idle",   0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 1,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("bc_acc",       0, 0, 1, 'h0777, 6, 0, 'h0000, 'h0000, 'h0000, 0, 0,   1, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("bc_resp",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'hCAFE, 1, 0,   0, 0, 1, 0, 'h0777, 'h0000, 0, 0, 'h0000);
        for (int i = 0; i < 4; i++)
            v("bc_hold",  0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 1, 6, 'hCAFE);
        v("bc_flush",     0, 1, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 1, 6, 'hCAFE);
        v("bc_idle",      0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 1,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("sf_acc",       0, 1, 1, 'h0099, 2, 1, 'h0500, 'h1357, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("sf_wait",      0, 1, 1, 'h0099, 2, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 1, 'h0500, 'h1357, 0, 0, 'h0000);
        v("sf_resp",      0, 1, 1, 'h0099, 2, 0, 'h0000, 'h0000, 'h0000, 1, 0,   0, 1, 0, 1, 'h0500, 'h1357, 0, 0, 'h0000);
        v("sf_idle1",     0, 1, 1, 'h0099, 2, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("sf_idle2",     0, 1, 1, 'h0099, 2, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);
        v("sf_end",       0, 0, 0, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0,   0, 0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            flush      = vecs[i].fl;
            ld_valid   = vecs[i].ldv;
            ld_addr    = vecs[i].lda;
            ld_dest    = vecs[i].ldd;
            st_valid   = vecs[i].stv;
            st_addr    = vecs[i].sta;
            st_data    = vecs[i].std;
            dmem_rdata = vecs[i].rd;
            dmem_resp  = vecs[i].resp;
            cdb_grant  = vecs[i].gnt;
            #2;
            chk_row(vecs[i]);
        end

        // Both requesters held high from reset: store wins the first tie, then alternation.
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; cdb_grant = 1'b1; dmem_rdata = 'h7777;
        st_valid = 1'b1; st_addr = 'h0A00; st_data = 'h00AA;
        ld_valid = 1'b1; ld_addr = 'h0B00; ld_dest = 4;
        ev_n = 0; ldre_cnt = 0; stack_cnt = 0; ev = ""; ev_req = "SLSL";
        for (int c = 0; c < 60 && ev_n < 4; c++) begin
            @(negedge clk);
            reset = 1'b0;
            dmem_resp = dmem_read | dmem_write;
            #2;
            if (dmem_read && dmem_write) chk("rr", "rd_wr_exclusive", 1, 0);
            if (ld_RE) ldre_cnt++;
            if (st_ack) begin
                stack_cnt++;
                ev = {ev, "S"};
                ev_n++;
            end else if (cdb_req && cdb_grant) begin
                ev = {ev, "L"};
                ev_n++;
            end
        end
        chk("rr", "event_count", ev_n, 4);
        for (int i = 0; i < 4; i++)
            chk("rr", "order", (i < ev.len()) ? ev[i] : 8'h3F, ev_req[i]);
        chk("rr", "ld_RE_count", ldre_cnt, 2);
        chk("rr", "st_ack_count", stack_cnt, 2);
        @(negedge clk);
        st_valid = 1'b0; ld_valid = 1'b0; dmem_resp = 1'b0; cdb_grant = 1'b0;

        // Reset pulse between clock edges while a store is in flight.
        @(negedge clk);
        st_valid = 1'b1; st_addr = 'h0C00; st_data = 'h0F0F;
        @(negedge clk);
        st_valid = 1'b0;
        #2;
        chk("rst_st", "dmem_write_before", dmem_write, 1);
        #1;
        reset = 1'b1; dmem_resp = 1'b1;
        #1;
        chk("rst_st", "dmem_write_async", dmem_write, 0);
        chk("rst_st", "st_ack", st_ack, 0);
        chk("rst_st", "dmem_address", dmem_address, 0);
        reset = 1'b0; dmem_resp = 1'b0;
        @(negedge clk);
        chk("rst_st", "idle_write", dmem_write, 0);
        st_valid = 1'b1; st_addr = 'h0D00; st_data = 'h0BAD;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        chk("st_after", "dmem_write", dmem_write, 1);
        chk("st_after", "dmem_address", dmem_address, 'h0D00);
        chk("st_after", "dmem_wdata", dmem_wdata, 'h0BAD);
        dmem_resp = 1'b1;
        #1;
        chk("st_after", "st_ack", st_ack, 1);
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        chk("st_after", "idle_write", dmem_write, 0);
        chk("st_after", "idle_ack", st_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The module SHALL take parameter data_width, default 16, which sets the address and data width.
REQ-002 The module SHALL take parameter rob_addr_width, default 3, which sets the ROB tag width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port flush, input, 1 bit: mispredict flush from issue control.
REQ-006 The module SHALL have port ld_valid, input, 1 bit: load buffer head ready (operand valid).
REQ-007 The module SHALL have port ld_addr, input, data_width: load buffer dmem_addr.
REQ-008 The module SHALL have port ld_dest, input, rob_addr_width: ROB tag of the head load.
REQ-009 The module SHALL have port ld_RE, output, 1 bit: one-cycle pop of the load buffer head.
REQ-010 The module SHALL have port st_valid, input, 1 bit: committed store pending from the ROB.
REQ-011 The module SHALL have port st_addr, input, data_width: store address.
REQ-012 The module SHALL have port st_data, input, data_width: store data.
REQ-013 The module SHALL have port st_ack, output, 1 bit: one-cycle pulse when the store has completed.
REQ-014 The module SHALL have port dmem_read, output, 1 bit: dcache read request.
REQ-015 The module SHALL have port dmem_write, output, 1 bit: dcache write request.
REQ-016 The module SHALL have port dmem_address, output, data_width: dcache address.
REQ-017 The module SHALL have port dmem_wdata, output, data_width: dcache write data.
REQ-018 The module SHALL have port dmem_rdata, input, data_width: dcache read data.
REQ-019 The module SHALL have port dmem_resp, input, 1 bit: dcache done; one-cycle pulse.
REQ-020 The module SHALL have port cdb_req, output, 1 bit: request to broadcast a load result.
REQ-021 The module SHALL have port cdb_tag, output, rob_addr_width: ROB tag of the load result.
REQ-022 The module SHALL have port cdb_data, output, data_width: the load result.
REQ-023 The module SHALL have port cdb_grant, input, 1 bit: CDB arbiter accepted the broadcast this cycle.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, LOAD, STORE and BCAST.
REQ-025 From IDLE, if only st_valid is high, the FSM SHALL go to STORE next cycle, latching st_addr and st_data.
REQ-026 From IDLE, if only ld_valid is high and flush is low, the FSM SHALL go to LOAD next cycle, latching ld_addr and ld_dest, and SHALL assert ld_RE for that single cycle.
REQ-027 If st_valid and ld_valid are both high in IDLE, a 1-bit last_served register SHALL pick the requester not served last (round-robin); last_served SHALL update on every accept.
REQ-028 In IDLE with flush high, loads SHALL NOT be accepted, ld_RE SHALL stay 0, and stores SHALL still be accepted.
REQ-029 In LOAD, dmem_read SHALL be 1 and dmem_address SHALL be the latched address, held stable until dmem_resp.
REQ-030 In STORE, dmem_write SHALL be 1 and dmem_address/dmem_wdata SHALL be the latched values, held stable until dmem_resp.
REQ-031 dmem_read and dmem_write SHALL never both be 1.
REQ-032 In STORE, on dmem_resp the FSM SHALL assert st_ack in the same cycle and return to IDLE next cycle.
REQ-033 In LOAD, on dmem_resp the module SHALL latch dmem_rdata and go to BCAST; if flush occurred during LOAD or in the resp cycle, it SHALL go to IDLE instead and discard the data.
REQ-034 The cache access SHALL never be aborted: a flush during LOAD SHALL still wait for dmem_resp.
REQ-035 In BCAST, cdb_req SHALL be 1 with cdb_tag/cdb_data stable until cdb_grant; the FSM SHALL return to IDLE the cycle after grant.
REQ-036 A flush in BCAST SHALL drop cdb_req next cycle and return to IDLE without a broadcast.
REQ-037 Stores SHALL be immune to flush, since they are committed.
REQ-038 A new request SHALL NOT be accepted in the cycle the FSM leaves a busy state; minimum spacing is one IDLE cycle.
REQ-039 All outputs SHALL be 0 except as set by REQ-026 and REQ-029 to REQ-036; dmem_address, dmem_wdata, cdb_tag and cdb_data SHALL be 0 when not qualified.
REQ-040 Minimum latencies SHALL be: load accept to cdb_req = dcache latency + 1 cycle; store accept to st_ack = dcache latency.

Reset
REQ-041 While reset is high, the FSM SHALL be in IDLE, every output 0, all latches 0, and last_served = load (store wins the first tie).
REQ-042 Reset asserted mid-LOAD or mid-STORE SHALL drop the dmem request immediately, asynchronously, with no ack and no broadcast.
REQ-043 After reset deasserts, the module SHALL accept requests on the first rising edge.

Verification
REQ-044 Bench: load ld_addr=0x1234, ld_dest=5, dcache resp after 3 cycles, immediate grant -> ld_RE 1 cycle; dmem_read held with address 0x1234; cdb_tag=5, cdb_data=rdata; IDLE after grant.
REQ-045 Bench: st_valid and ld_valid both held high after reset -> order store, load, store, load; ld_RE and st_ack counts match.
REQ-046 Bench: flush 1 cycle into LOAD with resp 2 cycles later -> dmem_read held until resp; cdb_req never asserts; IDLE.
REQ-047 Bench: cdb_grant withheld 4 cycles in BCAST -> cdb_req, cdb_tag and cdb_data stable for 4 cycles; flush on cycle 5 -> no broadcast.
REQ-048 Bench: reset pulse mid-STORE -> dmem_write drops without a clock edge; no st_ack; next store proceeds normally.
REQ-049 Bench: store in flight with flush high throughout -> st_ack still asserts; no load accepted while flush is high.
